input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner_pkg.sv | 17 +
 rtl/input_conditioner_debounce_channel.sv | 107 ++++++++++
 rtl/input_conditioner.sv | 86 ++++++++
 tb/tb_input_conditioner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and default timing constants for the board input conditioner.
package input_conditioner_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } deb_state_e;

    // 10 ms debounce and 1 s long press at a 100 MHz clock
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 32'd1_000_000;
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 32'd100_000_000;

    localparam int unsigned NUM_PB    = 2;
    localparam int unsigned NUM_DIPSW = 2;
    localparam int unsigned NUM_CH    = NUM_PB + NUM_DIPSW;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: 2-flop synchronizer, STABLE/CHANGING debounce FSM,
// edge pulses and a first-window tracker for the top-level valid flag.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic window_done_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int WW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WIN_FULL = WW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic [1:0]    primed_q;
    logic          sample;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [WW-1:0] win_q, win_d;

    assign sample = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sample != out_q) begin
                    state_d = CHANGING;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            CHANGING: begin
                if (sample == out_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = ~out_q;
                    rise_d  = ~out_q;
                    fall_d  = out_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The window starts once the synchronizer holds a real sample, so it
    // completes on the same edge as the earliest possible debounced change.
    always_comb begin
        win_d = win_q;
        if (primed_q[1] && (win_q != WIN_FULL)) begin
            win_d = win_q + WW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= {2{RESET_LEVEL}};
            primed_q <= 2'b00;
            state_q  <= STABLE;
            cnt_q    <= '0;
            out_q    <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            win_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            primed_q <= {primed_q[0], 1'b1};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            win_q    <= win_d;
        end
    end

    assign level_o       = out_q;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;
    assign window_done_o = (win_q == WIN_FULL);

endmodule

// File: rtl/input_conditioner.sv
// Debounces two active-low pushbuttons and two DIP switches for the PIO
// inputs and derives press/release/long-press and switch-change events.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [1:0] pb_raw,
    input  logic [1:0] dipsw_raw,
    output logic [1:0] pb_export,
    output logic [1:0] dipsw_export,
    output logic [1:0] pb_press,
    output logic [1:0] pb_release,
    output logic [1:0] pb_long,
    output logic       dipsw_change,
    output logic       inputs_valid
);

    localparam logic [31:0] LONG_FULL = 32'(LONG_PRESS_CYCLES);
    localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_CYCLES - 1);

    logic [NUM_CH-1:0] raw_all;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] win_done;

    assign raw_all = {dipsw_raw, pb_raw};

    // Channels 0..1 are pushbuttons (idle high), 2..3 are DIP switches.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     ((c < NUM_PB) ? 1'b1 : 1'b0)
        ) u_ch (
            .clk_i         (clk_clk),
            .rst_ni        (reset_reset_n),
            .raw_i         (raw_all[c]),
            .level_o       (level[c]),
            .rise_o        (rise[c]),
            .fall_o        (fall[c]),
            .window_done_o (win_done[c])
        );
    end

    assign pb_export    = level[NUM_PB-1:0];
    assign dipsw_export = level[NUM_CH-1:NUM_PB];
    assign pb_press     = fall[NUM_PB-1:0];
    assign pb_release   = rise[NUM_PB-1:0];
    assign dipsw_change = |(rise[NUM_CH-1:NUM_PB] | fall[NUM_CH-1:NUM_PB]);
    assign inputs_valid = &win_done;

    // Long-press pulse fires on the edge the hold count lands on the limit;
    // saturation keeps it from firing again while the button stays down.
    for (genvar i = 0; i < NUM_PB; i++) begin : g_hold
        logic [31:0] hold_q, hold_d;
        logic        long_q, long_d;

        always_comb begin
            hold_d = hold_q;
            long_d = 1'b0;
            if (pb_export[i]) begin
                hold_d = '0;
            end else if (hold_q != LONG_FULL) begin
                hold_d = hold_q + 32'd1;
                long_d = (hold_q == LONG_LAST);
            end
        end

        always_ff @(posedge clk_clk) begin
            if (!reset_reset_n) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign pb_long[i] = long_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scenarios plus randomized hold patterns, checked every cycle
// against a behavioural model of the debounce/long-press rules.
module tb_input_conditioner;

    localparam int D = 16;
    localparam int L = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pb_raw = 2'b11;
    logic [1:0] dip_raw = 2'b00;
    logic [1:0] pb_export, dipsw_export, pb_press, pb_release, pb_long;
    logic       dipsw_change, inputs_valid;

    always #5 clk = ~clk;

    input_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pb_raw        (pb_raw),
        .dipsw_raw     (dip_raw),
        .pb_export     (pb_export),
        .dipsw_export  (dipsw_export),
        .pb_press      (pb_press),
        .pb_release    (pb_release),
        .pb_long       (pb_long),
        .dipsw_change  (dipsw_change),
        .inputs_valid  (inputs_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: channels 0,1 = pb, 2,3 = dipsw.
    logic [3:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic [1:0] m_long;
    int         m_run[4];
    int         m_age[2];
    int         m_cyc;

    // Observation bookkeeping per directed phase.
    int ph_cyc, cnt_chg, first_valid, cyc_dip_rise[2];
    int cnt_press[2], cnt_rel[2], cnt_long[2];
    int cyc_press[2], cyc_rel[2], cyc_long[2];
    logic [1:0] prev_dip = 2'b00;

    task automatic model_step();
        logic [3:0] raw4;
        logic [3:0] old_out;
        raw4 = {dip_raw, pb_raw};
        m_rise = '0;
        m_fall = '0;
        m_long = '0;
        if (!rst_n) begin
            m_s1 = 4'b0011; m_s2 = 4'b0011; m_out = 4'b0011;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
            for (int i = 0; i < 2; i++) m_age[i] = 0;
            m_cyc = 0;
            return;
        end
        old_out = m_out;
        // A level is accepted after D consecutive evaluations disagree with it;
        // each evaluation sees the raw value from two edges earlier.
        for (int c = 0; c < 4; c++) begin
            if (m_s2[c] != m_out[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_out[c] = ~m_out[c];
                    if (m_out[c]) m_rise[c] = 1'b1; else m_fall[c] = 1'b1;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw4;
        for (int i = 0; i < 2; i++) begin
            if (old_out[i]) m_age[i] = 0;
            else m_age[i]++;
            m_long[i] = (m_age[i] == L);
        end
        m_cyc++;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic phase_start();
        ph_cyc = 0; cnt_chg = 0; first_valid = 0;
        for (int i = 0; i < 2; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
            cyc_press[i] = 0; cyc_rel[i] = 0; cyc_long[i] = 0;
            cyc_dip_rise[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pb_export",    pb_export,    m_out[1:0]);
        chk("dipsw_export", dipsw_export, m_out[3:2]);
        chk("pb_press",     pb_press,     m_fall[1:0]);
        chk("pb_release",   pb_release,   m_rise[1:0]);
        chk("pb_long",      pb_long,      m_long);
        chk("dipsw_change", {1'b0, dipsw_change}, {1'b0, |(m_rise[3:2] | m_fall[3:2])});
        chk("inputs_valid", {1'b0, inputs_valid}, {1'b0, (m_cyc >= D + 2)});
        ph_cyc++;
        for (int i = 0; i < 2; i++) begin
            if (pb_press[i]) begin cnt_press[i]++; if (cyc_press[i] == 0) cyc_press[i] = ph_cyc; end
            if (pb_release[i]) begin cnt_rel[i]++; if (cyc_rel[i] == 0) cyc_rel[i] = ph_cyc; end
            if (pb_long[i]) begin cnt_long[i]++; if (cyc_long[i] == 0) cyc_long[i] = ph_cyc; end
            if (dipsw_export[i] && !prev_dip[i] && cyc_dip_rise[i] == 0) cyc_dip_rise[i] = ph_cyc;
        end
        prev_dip = dipsw_export;
        if (dipsw_change) cnt_chg++;
        if (inputs_valid && first_valid == 0) first_valid = ph_cyc;
    endtask

    initial begin
        int len;
        phase_start();
        // Reset state, then release with dipsw raw = 10.
        repeat (3) tick();
        dip_raw = 2'b10;
        rst_n = 1'b1;
        phase_start();
        repeat (30) tick();
        chk_int("dip1_rise_cycle", cyc_dip_rise[1], 18);
        chk_int("dip_change_count", cnt_chg, 1);
        chk_int("valid_by_18", int'(first_valid > 0 && first_valid <= 18), 1);
        chk_int("no_press_idle", cnt_press[0] + cnt_press[1], 0);

        // Short glitch on pb0.
        phase_start();
        pb_raw = 2'b10;
        repeat (10) tick();
        pb_raw = 2'b11;
        repeat (30) tick();
        chk_int("glitch_press", cnt_press[0], 0);
        chk_int("glitch_release", cnt_rel[0], 0);

        // Clean press and release of pb0.
        phase_start();
        pb_raw = 2'b10;
        repeat (40) tick();
        chk_int("press0_cycle", cyc_press[0], 18);
        chk_int("press0_count", cnt_press[0], 1);
        phase_start();
        pb_raw = 2'b11;
        repeat (40) tick();
        chk_int("release0_cycle", cyc_rel[0], 18);
        chk_int("short_no_long", cnt_long[0], 0);

        // Long hold on pb1.
        phase_start();
        pb_raw = 2'b01;
        repeat (200) tick();
        chk_int("long1_count", cnt_long[1], 1);
        chk_int("long1_delay", cyc_long[1] - cyc_press[1], 64);
        pb_raw = 2'b11;
        repeat (40) tick();

        // Simultaneous pb0, pb1 and dipsw0 change.
        phase_start();
        pb_raw = 2'b00;
        dip_raw = 2'b11;
        repeat (40) tick();
        chk_int("sim_press0", cyc_press[0], 18);
        chk_int("sim_press1", cyc_press[1], 18);
        chk_int("sim_dip0", cyc_dip_rise[0], 18);
        chk_int("sim_change_count", cnt_chg, 1);
        pb_raw = 2'b11;
        repeat (40) tick();

        // Reset in the middle of a pb0 debounce.
        phase_start();
        pb_raw = 2'b10;
        repeat (12) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        pb_raw = 2'b11;
        rst_n = 1'b1;
        phase_start();
        repeat (30) tick();
        chk_int("post_reset_press", cnt_press[0] + cnt_press[1], 0);
        chk_int("post_reset_release", cnt_rel[0] + cnt_rel[1], 0);

        // Randomized hold patterns with occasional resets.
        for (int s = 0; s < 80; s++) begin
            pb_raw = 2'($urandom);
            dip_raw = 2'($urandom);
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 110))
                                              : int'($urandom_range(1, 30));
            repeat (len) tick();
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                repeat (int'($urandom_range(1, 3))) tick();
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
